// File: rtl/corr_pkg.sv
// rtl/corr_pkg.sv - shared correlator sizing constants and sequencer state encoding
package corr_pkg;

    localparam int DEPTH = 256;
    localparam int AW    = 8;
    localparam int DIV_W = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_PRE   = 2'd2,
        ST_SWEEP = 2'd3
    } state_t;

endpackage

// File: rtl/corr_trig_sync.sv
// rtl/corr_trig_sync.sv - two-flop synchroniser and rising-edge detect for the external trigger
module corr_trig_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic trig,
    output logic rise
);

    // sync_q[1] is the synchronised level; sync_q[2] holds it one more cycle for edge detect
    logic [2:0] sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[1:0], trig};
        end
    end

    assign rise = sync_q[1] & ~sync_q[2];

endmodule

// File: rtl/corr_shift_sched.sv
// rtl/corr_shift_sched.sv - sample strobe scheduler and lag tagger for the correlator shift RAM
module corr_shift_sched
    import corr_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             trig_sel,
    input  logic [DIV_W-1:0] div_cfg,
    input  logic             ext_trig,
    input  logic             clr_stats,
    output logic             sin,
    output logic             lag_valid,
    output logic [AW-1:0]    lag_idx,
    output logic             lag_first,
    output logic             lag_last,
    output logic             busy,
    output logic             overrun,
    output logic [15:0]      sample_cnt,
    output logic [7:0]       miss_cnt
);

    localparam logic [DIV_W-1:0] MIN_DIV  = DIV_W'(DEPTH + 2);
    localparam logic [AW-1:0]    LAST_IDX = AW'(DEPTH - 1);

    state_t           state, state_nx;
    logic [DIV_W-1:0] eff_div, div_cnt;
    logic [AW-1:0]    sweep_cnt;
    logic             ext_rise, div_hit, trig_event, issue, drop;

    corr_trig_sync u_trig_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .trig  (ext_trig),
        .rise  (ext_rise)
    );

    assign div_hit    = (state != ST_IDLE) && (div_cnt == eff_div - DIV_W'(1));
    assign trig_event = trig_sel ? ext_rise : div_hit;
    assign busy       = (state == ST_PRE) || (state == ST_SWEEP);
    assign drop       = trig_event && busy;

    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE:  if (en) state_nx = ST_WAIT;
            ST_WAIT: begin
                if (trig_event)  state_nx = ST_PRE;
                else if (!en)    state_nx = ST_IDLE;
            end
            ST_PRE:   state_nx = ST_SWEEP;
            ST_SWEEP: if (sweep_cnt == LAST_IDX) state_nx = en ? ST_WAIT : ST_IDLE;
            default:  state_nx = ST_IDLE;
        endcase
    end

    assign issue = (state == ST_WAIT) && (state_nx == ST_PRE);

    // Divider keeps running through PRE/SWEEP so the sample period stays absolute
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            sin       <= 1'b0;
            eff_div   <= '0;
            div_cnt   <= '0;
            sweep_cnt <= '0;
        end else begin
            state <= state_nx;
            sin   <= issue;
            if (state == ST_IDLE) begin
                div_cnt <= '0;
                if (en) eff_div <= (div_cfg < MIN_DIV) ? MIN_DIV : div_cfg;
            end else begin
                div_cnt <= div_hit ? '0 : div_cnt + DIV_W'(1);
            end
            sweep_cnt <= (state == ST_SWEEP) ? sweep_cnt + AW'(1) : '0;
        end
    end

    // One register stage here lines lag tags up with the RAM's dshift word
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lag_valid <= 1'b0;
            lag_idx   <= '0;
            lag_first <= 1'b0;
            lag_last  <= 1'b0;
        end else begin
            lag_valid <= (state == ST_SWEEP);
            lag_idx   <= (state == ST_SWEEP) ? sweep_cnt : '0;
            lag_first <= (state == ST_SWEEP) && (sweep_cnt == '0);
            lag_last  <= (state == ST_SWEEP) && (sweep_cnt == LAST_IDX);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overrun    <= 1'b0;
            sample_cnt <= '0;
            miss_cnt   <= '0;
        end else if (clr_stats) begin
            overrun    <= 1'b0;
            sample_cnt <= '0;
            miss_cnt   <= '0;
        end else begin
            if (issue) sample_cnt <= sample_cnt + 16'd1;
            if (drop) begin
                overrun <= 1'b1;
                if (miss_cnt != 8'hFF) miss_cnt <= miss_cnt + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_corr_shift_sched.sv
// tb/tb_corr_shift_sched.sv - randomized self-checking bench for corr_shift_sched
module tb_corr_shift_sched;

    localparam int DEPTH   = 256;
    localparam int MIN_GAP = DEPTH + 2;

    logic        clk = 1'b0;
    logic        rst_n, en, trig_sel, ext_trig, clr_stats;
    logic [15:0] div_cfg;
    logic        sin, lag_valid, lag_first, lag_last, busy, overrun;
    logic [7:0]  lag_idx, miss_cnt;
    logic [15:0] sample_cnt;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int sin_q[$];
    int last_sin = 0;
    bit has_sin = 1'b0;
    int lag_err = 0;
    int last_cnt = 0;

    corr_shift_sched dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .trig_sel   (trig_sel),
        .div_cfg    (div_cfg),
        .ext_trig   (ext_trig),
        .clr_stats  (clr_stats),
        .sin        (sin),
        .lag_valid  (lag_valid),
        .lag_idx    (lag_idx),
        .lag_first  (lag_first),
        .lag_last   (lag_last),
        .busy       (busy),
        .overrun    (overrun),
        .sample_cnt (sample_cnt),
        .miss_cnt   (miss_cnt)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Shift RAM model: a strobe at cycle s means dshift carries lag k at cycle s+2+k
    always @(negedge clk) begin
        if (!rst_n) begin
            has_sin = 1'b0;
        end else begin : ram_model
            int d;
            bit exp_v;
            d = cyc - last_sin;
            exp_v = has_sin && (d >= 2) && (d <= DEPTH + 1);
            if (lag_valid !== exp_v) lag_err++;
            else if (exp_v && ((int'(lag_idx) != d - 2) || (lag_first !== (d == 2)) || (lag_last !== (d == DEPTH + 1)))) lag_err++;
            else if (!exp_v && ((lag_first !== 1'b0) || (lag_last !== 1'b0))) lag_err++;
            if (lag_last === 1'b1) last_cnt++;
            if (sin === 1'b1) begin
                sin_q.push_back(cyc);
                last_sin = cyc;
                has_sin  = 1'b1;
            end
        end
    end

    function automatic int eff_of(input int d);
        return (d < MIN_GAP) ? MIN_GAP : d;
    endfunction

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic go_idle();
        en = 1'b0;
        tick(DEPTH + 40);
        clr_stats = 1'b1;
        tick(1);
        clr_stats = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; en = 1'b0; trig_sel = 1'b0; div_cfg = '0; ext_trig = 1'b0; clr_stats = 1'b0;
        tick(3);
        n_cmp++;
        if ({sin, lag_valid, lag_idx, lag_first, lag_last, busy, overrun, sample_cnt, miss_cnt} !== '0) begin
            n_bad++; $display("FAIL reset_outputs: got %h want 0", {sin, lag_valid, lag_idx, lag_first, lag_last, busy, overrun, sample_cnt, miss_cnt});
        end
        rst_n = 1'b1;
        tick(5);
        n_cmp++;
        if ({sin, lag_valid, lag_idx, lag_first, lag_last, busy, overrun, sample_cnt, miss_cnt} !== '0) begin
            n_bad++; $display("FAIL idle_outputs: got %h want 0", {sin, lag_valid, lag_idx, lag_first, lag_last, busy, overrun, sample_cnt, miss_cnt});
        end
    endtask

    task automatic test_internal_period(input string name, input int div, input int nper);
        int c, eff, bad;
        go_idle();
        trig_sel = 1'b0;
        div_cfg = 16'(div);
        eff = eff_of(div);
        c = cyc;
        en = 1'b1;
        sin_q.delete();
        lag_err = 0;
        tick(1);
        div_cfg = 16'($urandom);
        tick(eff * nper + 3);
        n_cmp++;
        if (sin_q.size() != nper) begin n_bad++; $display("FAIL %s_sin_count: got %0d want %0d", name, sin_q.size(), nper); end
        bad = 0;
        foreach (sin_q[k]) if (sin_q[k] != c + 1 + eff * (k + 1)) bad++;
        n_cmp++;
        if (bad != 0) begin n_bad++; $display("FAIL %s_sin_times: got %0d off-period strobes want 0 (period %0d)", name, bad, eff); end
        n_cmp++;
        if (sample_cnt !== 16'(nper)) begin n_bad++; $display("FAIL %s_sample_cnt: got %0d want %0d", name, sample_cnt, nper); end
        n_cmp++;
        if ({overrun, miss_cnt} !== 9'd0) begin n_bad++; $display("FAIL %s_no_overrun: got overrun=%b miss=%0d want 0/0", name, overrun, miss_cnt); end
        n_cmp++;
        if (lag_err != 0) begin n_bad++; $display("FAIL %s_lag_align: got %0d bad cycles want 0", name, lag_err); end
    endtask

    task automatic test_ext_overrun();
        int c, last_acc, n_acc, n_miss, bad, gap, want_miss;
        int exp_q[$];
        go_idle();
        trig_sel = 1'b1;
        en = 1'b1;
        tick(5);
        sin_q.delete();
        lag_err = 0;
        last_acc = -100000; n_acc = 0; n_miss = 0;
        for (int i = 0; i < 600; i++) begin
            gap = (i < 30) ? 100 : int'($urandom_range(30, 130));
            c = cyc;
            ext_trig = 1'b1;
            if (c + 3 - last_acc >= MIN_GAP) begin
                exp_q.push_back(c + 3); last_acc = c + 3; n_acc++;
            end else begin
                n_miss++;
            end
            tick(3);
            ext_trig = 1'b0;
            tick(gap - 3);
        end
        tick(10);
        n_cmp++;
        if (sin_q.size() != exp_q.size()) begin n_bad++; $display("FAIL ext_sin_count: got %0d want %0d", sin_q.size(), exp_q.size()); end
        bad = 0;
        foreach (exp_q[k]) if (k >= sin_q.size() || sin_q[k] != exp_q[k]) bad++;
        n_cmp++;
        if (bad != 0) begin n_bad++; $display("FAIL ext_sin_times: got %0d misplaced strobes want 0", bad); end
        want_miss = (n_miss > 255) ? 255 : n_miss;
        n_cmp++;
        if (miss_cnt !== 8'(want_miss)) begin n_bad++; $display("FAIL ext_miss_cnt: got %0d want %0d", miss_cnt, want_miss); end
        n_cmp++;
        if (overrun !== (n_miss > 0)) begin n_bad++; $display("FAIL ext_overrun: got %b want %b", overrun, n_miss > 0); end
        n_cmp++;
        if (sample_cnt !== 16'(n_acc)) begin n_bad++; $display("FAIL ext_sample_cnt: got %0d want %0d", sample_cnt, n_acc); end
        n_cmp++;
        if (lag_err != 0) begin n_bad++; $display("FAIL ext_lag_align: got %0d bad cycles want 0", lag_err); end
    endtask

    task automatic test_en_drop();
        int c, eff, div, found, lc0, got;
        go_idle();
        trig_sel = 1'b0;
        div_cfg = 16'd300;
        en = 1'b1;
        lag_err = 0;
        found = 0;
        for (int i = 0; i < 1000 && found == 0; i++) begin
            tick(1);
            if (lag_valid === 1'b1 && lag_idx === 8'd10) found = 1;
        end
        n_cmp++;
        if (found != 1) begin n_bad++; $display("FAIL en_drop_reach_idx10: got found=%0d want 1", found); end
        en = 1'b0;
        lc0 = last_cnt;
        sin_q.delete();
        tick(700);
        n_cmp++;
        if (last_cnt - lc0 != 1) begin n_bad++; $display("FAIL en_drop_sweep_completes: got %0d lag_last want 1", last_cnt - lc0); end
        n_cmp++;
        if (sin_q.size() != 0) begin n_bad++; $display("FAIL en_drop_no_sin: got %0d strobes want 0", sin_q.size()); end
        n_cmp++;
        if (busy !== 1'b0) begin n_bad++; $display("FAIL en_drop_idle: got busy=%b want 0", busy); end
        div = int'($urandom_range(0, 700));
        div_cfg = 16'(div);
        eff = eff_of(div);
        c = cyc;
        en = 1'b1;
        tick(eff + 4);
        got = (sin_q.size() > 0) ? sin_q[0] : -1;
        n_cmp++;
        if (sin_q.size() != 1 || got != c + 1 + eff) begin n_bad++; $display("FAIL en_reenable_first_sin: got n=%0d at %0d want 1 at %0d", sin_q.size(), got, c + 1 + eff); end
        n_cmp++;
        if (lag_err != 0) begin n_bad++; $display("FAIL en_drop_lag_align: got %0d bad cycles want 0", lag_err); end
    endtask

    task automatic test_clr_collision();
        int ca, cb, cc, got;
        go_idle();
        trig_sel = 1'b1;
        en = 1'b1;
        tick(5);
        sin_q.delete();
        lag_err = 0;
        ca = cyc; ext_trig = 1'b1; tick(3); ext_trig = 1'b0;
        tick(int'($urandom_range(20, 60)));
        cb = cyc; ext_trig = 1'b1; tick(3); ext_trig = 1'b0; tick(2);
        n_cmp++;
        if ({overrun, miss_cnt} !== {1'b1, 8'd1}) begin n_bad++; $display("FAIL clr_pre_drop: got overrun=%b miss=%0d want 1/1 (edge at %0d)", overrun, miss_cnt, cb); end
        tick(int'($urandom_range(20, 60)));
        cc = cyc; ext_trig = 1'b1; tick(2);
        clr_stats = 1'b1; tick(1);
        clr_stats = 1'b0; ext_trig = 1'b0;
        n_cmp++;
        if ({overrun, miss_cnt, sample_cnt} !== 25'd0) begin n_bad++; $display("FAIL clr_wins: got overrun=%b miss=%0d samples=%0d want 0/0/0 (edge at %0d)", overrun, miss_cnt, sample_cnt, cc); end
        tick(5);
        got = (sin_q.size() > 0) ? sin_q[0] : -1;
        n_cmp++;
        if (sin_q.size() != 1 || got != ca + 3) begin n_bad++; $display("FAIL clr_single_sin: got n=%0d at %0d want 1 at %0d", sin_q.size(), got, ca + 3); end
        n_cmp++;
        if (lag_err != 0) begin n_bad++; $display("FAIL clr_lag_align: got %0d bad cycles want 0", lag_err); end
    endtask

    task automatic test_reset_mid();
        int c, div, eff, found, got;
        go_idle();
        trig_sel = 1'b0;
        div = int'($urandom_range(270, 600));
        div_cfg = 16'(div);
        eff = eff_of(div);
        en = 1'b1;
        found = 0;
        for (int i = 0; i < 1500 && found == 0; i++) begin
            tick(1);
            if (lag_valid === 1'b1 && lag_idx === 8'd50) found = 1;
        end
        n_cmp++;
        if (found != 1) begin n_bad++; $display("FAIL rst_mid_reach_idx50: got found=%0d want 1", found); end
        #2 rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({sin, lag_valid, lag_idx, lag_first, lag_last, busy, overrun, sample_cnt, miss_cnt} !== '0) begin
            n_bad++; $display("FAIL rst_mid_async_clear: got %h want 0", {sin, lag_valid, lag_idx, lag_first, lag_last, busy, overrun, sample_cnt, miss_cnt});
        end
        tick(3);
        sin_q.delete();
        lag_err = 0;
        c = cyc;
        rst_n = 1'b1;
        tick(eff + 270);
        got = (sin_q.size() > 0) ? sin_q[0] : -1;
        n_cmp++;
        if (sin_q.size() != 1 || got != c + 1 + eff) begin n_bad++; $display("FAIL rst_mid_resume_sin: got n=%0d at %0d want 1 at %0d", sin_q.size(), got, c + 1 + eff); end
        n_cmp++;
        if (sample_cnt !== 16'd1) begin n_bad++; $display("FAIL rst_mid_sample_cnt: got %0d want 1", sample_cnt); end
        n_cmp++;
        if (lag_err != 0) begin n_bad++; $display("FAIL rst_mid_lag_align: got %0d bad cycles want 0", lag_err); end
    endtask

    initial begin
        test_reset();
        test_internal_period("div300", 300, 10);
        test_internal_period("div100", 100, 10);
        test_internal_period("divrand", int'($urandom_range(0, 600)), 4);
        test_ext_overrun();
        test_en_drop();
        test_clr_collision();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: got simulation time limit want completion");
        $fatal(1);
    end

endmodule
